imem_loader: RTL and testbench

- Boot-time program loader that sits upstream of the core's instruction memory.
- Receives a framed byte stream through a valid/ready handshake, assembles little-endian instruction words, and writes them to instruction memory from address 0 upward.
- Holds the core in reset until a complete frame with a matching checksum has been written.
- Frame format: magic 0xA5, word count N (16-bit, little-endian), N words of BPW bytes each (little-endian), 1-byte checksum.

---
 rtl/imem_loader.sv | 214 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream, writes
// little-endian words from address 0 upward and releases the core on a good checksum.
module imem_loader #(
    parameter int unsigned SIZE_DATA   = 24,
    parameter int unsigned SIZE_ADDR   = 24,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic [7:0]           iw_byte,
    input  logic                 iw_byte_valid,
    output logic                 ow_byte_ready,
    input  logic                 iw_restart,
    output logic                 ow_mem_we,
    output logic [SIZE_ADDR-1:0] ow_mem_addr,
    output logic [SIZE_DATA-1:0] ow_mem_wdata,
    output logic                 ow_core_rst,
    output logic                 ow_done,
    output logic                 ow_err,
    output logic [1:0]           ow_err_code
);

    localparam int unsigned BPW    = (SIZE_DATA + 7) / 8;
    localparam int unsigned WORD_W = BPW * 8;
    localparam int unsigned IDX_W  = (BPW < 2) ? 1 : $clog2(BPW);
    localparam int unsigned TMO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  MAGIC  = 8'hA5;

    typedef enum logic [2:0] {
        S_MAGIC, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            n_q, n_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SIZE_ADDR-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [7:0]             csum_q, csum_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [SIZE_ADDR-1:0]   mem_addr_q, mem_addr_d;
    logic [SIZE_DATA-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   core_rst_q, core_rst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;

    logic                   accept_c;
    logic                   counting_c;
    logic [15:0]            count_c;
    logic [TMO_W-1:0]       tmo_inc_c;

    assign accept_c   = iw_byte_valid && byte_ready_q;
    assign counting_c = (state_q == S_CNT0) || (state_q == S_CNT1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign count_c    = {iw_byte, n_q[7:0]};
    assign tmo_inc_c  = tmo_q + TMO_W'(1);

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        word_d      = word_q;
        csum_d      = csum_q;
        tmo_d       = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_MAGIC: begin
                if (accept_c && iw_byte == MAGIC) begin
                    state_d = S_CNT0;
                end
            end
            S_CNT0: begin
                if (accept_c) begin
                    n_d[7:0] = iw_byte;
                    csum_d   = csum_q ^ iw_byte;
                    state_d  = S_CNT1;
                end
            end
            S_CNT1: begin
                if (accept_c) begin
                    n_d    = count_c;
                    csum_d = csum_q ^ iw_byte;
                    if (32'(count_c) > DEPTH) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd2;
                    end else if (count_c == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        addr_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    word_d[32'(idx_q) * 8 +: 8] = iw_byte;
                    csum_d = csum_q ^ iw_byte;
                    if (32'(idx_q) == BPW - 1) begin
                        state_d = S_WRITE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = word_q[SIZE_DATA-1:0];
                addr_d      = addr_q + SIZE_ADDR'(1);
                idx_d       = '0;
                if (32'(addr_q) + 32'd1 == 32'(n_q)) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    if (iw_byte == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = 2'd1;
                    end
                end
            end
            default: ;
        endcase

        // Idle counter only advances while the frame stalls in a byte-consuming state
        if (TIMEOUT_CYC != 0 && counting_c && !accept_c) begin
            if (tmo_inc_c == TMO_W'(TIMEOUT_CYC)) begin
                state_d    = S_ERR;
                err_code_d = 2'd3;
            end else begin
                tmo_d = tmo_inc_c;
            end
        end

        // Restart wins over a byte accepted this cycle; an in-flight write still lands
        if (iw_restart) begin
            state_d    = S_MAGIC;
            n_d        = '0;
            idx_d      = '0;
            addr_d     = '0;
            csum_d     = '0;
            tmo_d      = '0;
            err_code_d = 2'd0;
        end

        byte_ready_d = (state_d == S_MAGIC) || (state_d == S_CNT0) || (state_d == S_CNT1) ||
                       (state_d == S_DATA)  || (state_d == S_CSUM);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
        core_rst_d   = (state_d != S_DONE);
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q      <= S_MAGIC;
            n_q          <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            tmo_q        <= '0;
            byte_ready_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign ow_byte_ready = byte_ready_q;
    assign ow_mem_we     = mem_we_q;
    assign ow_mem_addr   = mem_addr_q;
    assign ow_mem_wdata  = mem_wdata_q;
    assign ow_core_rst   = core_rst_q;
    assign ow_done       = done_q;
    assign ow_err        = err_q;
    assign ow_err_code   = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built into a byte queue with the
// expected memory writes queued alongside, and writes are checked as they appear.
module tb_imem_loader;

    localparam int unsigned SD = 24;
    localparam int unsigned SA = 24;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } tx_t;

    typedef struct {
        logic [SA-1:0] addr;
        logic [SD-1:0] data;
    } wr_t;

    logic          iw_clk;
    logic          iw_rst;
    logic [7:0]    iw_byte;
    logic          iw_byte_valid;
    logic          ow_byte_ready;
    logic          iw_restart;
    logic          ow_mem_we;
    logic [SA-1:0] ow_mem_addr;
    logic [SD-1:0] ow_mem_wdata;
    logic          ow_core_rst;
    logic          ow_done;
    logic          ow_err;
    logic [1:0]    ow_err_code;

    int  vectors;
    int  miscompares;
    int  cyc;
    int  last_word_acc;
    int  stalls;
    tx_t txq[$];
    wr_t exp_q[$];

    imem_loader #(
        .SIZE_DATA  (SD),
        .SIZE_ADDR  (SA),
        .DEPTH      (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_byte      (iw_byte),
        .iw_byte_valid(iw_byte_valid),
        .ow_byte_ready(ow_byte_ready),
        .iw_restart   (iw_restart),
        .ow_mem_we    (ow_mem_we),
        .ow_mem_addr  (ow_mem_addr),
        .ow_mem_wdata (ow_mem_wdata),
        .ow_core_rst  (ow_core_rst),
        .ow_done      (ow_done),
        .ow_err       (ow_err),
        .ow_err_code  (ow_err_code)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    always @(posedge iw_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and retire any memory write seen there
    task automatic step_neg();
        wr_t e;
        @(negedge iw_clk);
        if (!iw_rst && ow_mem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         ow_mem_addr, ow_mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({ow_mem_addr, ow_mem_wdata} !== {e.addr, e.data}) begin
                    miscompares++;
                    $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                             ow_mem_addr, ow_mem_wdata, e.addr, e.data);
                end
            end
            vectors++;
            if (cyc !== last_word_acc + 1) begin
                miscompares++;
                $display("FAIL write_latency: write in cycle %0d, required cycle %0d",
                         cyc, last_word_acc + 1);
            end
        end
    endtask

    task automatic cycle();
        step_neg();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int guard;
        guard         = 0;
        iw_byte       = b;
        iw_byte_valid = 1'b1;
        step_neg();
        while (!ow_byte_ready && guard < 50) begin
            stalls++;
            guard++;
            step_neg();
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake: byte %h not accepted within 50 cycles", b);
        end
        @(posedge iw_clk);
        #1;
        if (last) last_word_acc = cyc;
    endtask

    // Queue a frame of n 3-byte words; byte k of the payload is (k+1)*step.
    // csum_ovr < 0 uses the true checksum; only the first max_bytes are queued.
    task automatic build_frame(input int n, input int step, input int csum_ovr, input int max_bytes);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] n16;
        wr_t         w;
        n16 = 16'(n);
        cs  = n16[7:0] ^ n16[15:8];
        txq.push_back('{b: 8'hA5, last: 1'b0});
        txq.push_back('{b: n16[7:0], last: 1'b0});
        txq.push_back('{b: n16[15:8], last: 1'b0});
        for (int i = 0; i < n; i++) begin
            w.addr = SA'(i);
            w.data = '0;
            for (int j = 0; j < 3; j++) begin
                b = 8'((i * 3 + j + 1) * step);
                w.data[j*8 +: 8] = b;
                cs = cs ^ b;
                txq.push_back('{b: b, last: (j == 2)});
            end
            if (3 + i * 3 + 3 <= max_bytes) exp_q.push_back(w);
        end
        txq.push_back('{b: (csum_ovr < 0) ? cs : 8'(csum_ovr), last: 1'b0});
        while (txq.size() > max_bytes) void'(txq.pop_back());
    endtask

    task automatic send_frame();
        tx_t t;
        while (txq.size() > 0) begin
            t = txq.pop_front();
            send_byte(t.b, t.last);
        end
        iw_byte_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        iw_byte_valid = 1'b0;
        iw_restart    = 1'b1;
        cycle();
        iw_restart    = 1'b0;
    endtask

    task automatic test_reset();
        iw_rst        = 1'b1;
        iw_byte       = 8'h00;
        iw_byte_valid = 1'b0;
        iw_restart    = 1'b0;
        #2;
        vectors++;
        if ({ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_core_rst, ow_done, ow_err, ow_err_code, ow_byte_ready}
            !== {1'b0, 24'd0, 24'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: we=%b addr=%h data=%h core_rst=%b done=%b err=%b code=%0d ready=%b",
                     ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_core_rst, ow_done, ow_err, ow_err_code, ow_byte_ready);
        end
        step_neg();
        iw_rst = 1'b0;
        @(posedge iw_clk);
        #1;
        vectors++;
        if ({ow_core_rst, ow_done, ow_byte_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL post_reset_idle: core_rst=%b done=%b ready=%b, required 1 0 1",
                     ow_core_rst, ow_done, ow_byte_ready);
        end
    endtask

    // Payload 11..66; checksum of this frame is 0x75
    task automatic test_load();
        build_frame(2, 8'h11, -1, 1000);
        send_frame();
        vectors++;
        if ({ow_done, ow_core_rst, ow_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL load_done: done=%b core_rst=%b err=%b, required 1 0 0", ow_done, ow_core_rst, ow_err);
        end
        cycle();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL load_writes: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        pulse_restart();
        vectors++;
        if ({ow_done, ow_core_rst, ow_err} !== 3'b010) begin
            miscompares++;
            $display("FAIL restart_clears: done=%b core_rst=%b err=%b, required 0 1 0", ow_done, ow_core_rst, ow_err);
        end
        build_frame(2, 8'h11, 8'h08, 1000);
        send_frame();
        vectors++;
        if ({ow_err, ow_err_code, ow_core_rst, ow_done} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bad_csum: err=%b code=%0d core_rst=%b done=%b, required 1 1 1 0",
                     ow_err, ow_err_code, ow_core_rst, ow_done);
        end
        cycle();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL bad_csum_writes: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_size();
        pulse_restart();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        iw_byte_valid = 1'b0;
        vectors++;
        if ({ow_err, ow_err_code, ow_core_rst, ow_byte_ready} !== {1'b1, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL size_err: err=%b code=%0d core_rst=%b ready=%b, required 1 2 1 0",
                     ow_err, ow_err_code, ow_core_rst, ow_byte_ready);
        end
        repeat (4) cycle();
    endtask

    task automatic test_garbage();
        pulse_restart();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        build_frame(0, 1, -1, 1000);
        send_frame();
        vectors++;
        if ({ow_done, ow_core_rst, ow_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL garbage_done: done=%b core_rst=%b err=%b, required 1 0 0", ow_done, ow_core_rst, ow_err);
        end
        repeat (3) cycle();
    endtask

    task automatic test_timeout();
        pulse_restart();
        build_frame(2, 8'h21, -1, 7);
        send_frame();
        // i-th falling edge shows the state after (i-1) idle clock edges
        for (int i = 1; i <= 17; i++) begin
            step_neg();
            vectors++;
            if ({ow_err, ow_err_code} !== ((i == 17) ? 3'b111 : 3'b000)) begin
                miscompares++;
                $display("FAIL timeout_edge%0d: err=%b code=%0d, required err=%0d", i, ow_err, ow_err_code, (i == 17));
            end
        end
        @(posedge iw_clk);
        #1;
        pulse_restart();
        build_frame(1, 8'h09, -1, 1000);
        send_frame();
        vectors++;
        if ({ow_err, ow_done, ow_core_rst} !== 3'b010) begin
            miscompares++;
            $display("FAIL timeout_recover: err=%b done=%b core_rst=%b, required 0 1 0", ow_err, ow_done, ow_core_rst);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        pulse_restart();
        stalls = 0;
        build_frame(3, 8'h0d, -1, 1000);
        send_frame();
        vectors++;
        if (stalls !== 3) begin
            miscompares++;
            $display("FAIL ready_stalls: %0d not-ready cycles, required 3", stalls);
        end
        vectors++;
        if (ow_done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_done: done=%b, required 1", ow_done);
        end
        cycle();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_writes: %0d writes missing, required 0", exp_q.size());
        end
        pulse_restart();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        #3;
        iw_rst = 1'b1;
        #1;
        vectors++;
        if ({ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_core_rst, ow_done, ow_err, ow_err_code, ow_byte_ready}
            !== {1'b0, 24'd0, 24'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: we=%b addr=%h data=%h core_rst=%b done=%b err=%b code=%0d ready=%b",
                     ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_core_rst, ow_done, ow_err, ow_err_code, ow_byte_ready);
        end
        step_neg();
        iw_byte_valid = 1'b0;
        iw_rst        = 1'b0;
        @(posedge iw_clk);
        #1;
        build_frame(1, 8'h31, -1, 1000);
        send_frame();
        vectors++;
        if ({ow_done, ow_core_rst} !== 2'b10) begin
            miscompares++;
            $display("FAIL after_reset_load: done=%b core_rst=%b, required 1 0", ow_done, ow_core_rst);
        end
        cycle();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        last_word_acc = 0;
        stalls        = 0;
        test_reset();
        test_load();
        test_bad_csum();
        test_size();
        test_garbage();
        test_timeout();
        test_back_to_back();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL final_scoreboard: %0d writes never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
